boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000: byte address of the first loaded word.
REQ-002 Parameter TIMEOUT, default 16'd65535: idle cycles allowed between accepted bytes during a load.
REQ-003 The module SHALL use a single clock, clk, and an asynchronous active-low reset, rst.
REQ-004 clk  input  1  system clock, all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 start  input  1  pulse that begins a program load.
REQ-007 byte_data  input  8  incoming program byte.
REQ-008 byte_valid  input  1  byte_data valid.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 cpu_addr  input  16  CPU memory address.
REQ-011 cpu_dout  input  16  CPU write data.
REQ-012 cpu_oe  input  1  CPU read enable.
REQ-013 cpu_we  input  1  CPU write enable.
REQ-014 cpu_din  output  16  read data to the CPU.
REQ-015 cpu_rst  output  1  CPU reset, active-high, synchronous to clk.
REQ-016 mem_rdata  input  16  memory read data.
REQ-017 mem_addr  output  16  memory address.
REQ-018 mem_wdata  output  16  memory write data.
REQ-019 mem_oe  output  1  memory read enable.
REQ-020 mem_we  output  1  memory write enable.
REQ-021 busy, done, err  output  1 each  load in progress, program running, load aborted by timeout.

Function
REQ-022 States SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE and RUN.
REQ-023 A byte SHALL be accepted only on a rising edge with byte_valid=1 and byte_ready=1.
- byte_ready=1 exactly in LEN_HI, LEN_LO, DATA_HI and DATA_LO.
REQ-024 IDLE: when start=1, go to LEN_HI and clear err and done.
REQ-025 Word count is received high byte first:
- LEN_HI -> LEN_LO on an accepted byte.
- LEN_LO -> RUN if the count is 0; otherwise -> DATA_HI with ptr=BASE_ADDR.
REQ-026 Data words are received high byte first:
- DATA_HI -> DATA_LO on an accepted byte.
- DATA_LO -> WRITE on an accepted byte.
REQ-027 WRITE lasts exactly one cycle:
- mem_we=1, mem_addr=ptr, mem_wdata={hi,lo}.
- ptr increments by 2 modulo 2^16; wrap from 16'hFFFE to 16'h0000 is legal.
- remaining count decrements by 1; next state is RUN if it reaches 0, else DATA_HI.
REQ-028 Outside RUN the loader SHALL drive the memory port:
- mem_oe=0 and mem_addr=ptr.
- mem_we=1 only in WRITE.
REQ-029 In RUN, mem_addr, mem_wdata, mem_oe and mem_we SHALL combinationally equal cpu_addr, cpu_dout, cpu_oe and cpu_we.
REQ-030 cpu_din SHALL equal mem_rdata in all states.
REQ-031 cpu_rst SHALL be registered and 0 only while in RUN:
- deasserts on the first cycle in RUN;
- reasserts on the first cycle after leaving RUN.
REQ-032 start=1 in RUN SHALL go to LEN_HI (reload). start SHALL be ignored in all other non-IDLE states.
REQ-033 busy=1 in LEN_HI through WRITE; done=1 in RUN.
REQ-034 An idle counter SHALL count consecutive cycles in LEN_HI, LEN_LO, DATA_HI or DATA_LO without an accepted byte.
- Cleared on each accepted byte and on entry to LEN_HI.
- On reaching TIMEOUT: set err=1 and go to IDLE.
- err holds until the next start.
REQ-035 Counters SHALL be 16 bits with no saturation beyond the rules above.

Reset
REQ-036 While rst=0, asynchronously, including mid-load:
- state=IDLE, ptr=BASE_ADDR, counters=0;
- cpu_rst=1, byte_ready=0, mem_we=0, mem_oe=0;
- mem_addr=BASE_ADDR, mem_wdata=0;
- busy=0, done=0, err=0.
REQ-037 Operation SHALL resume on the first rising edge after rst returns to 1.

Verification
REQ-038 Reset check: assert rst=0 mid-DATA_LO -> all outputs match REQ-036 without a clock edge.
REQ-039 Basic load: start, then bytes 00 02 AA BB CC DD.
- 0xAABB written at 0x0000, then 0xCCDD at 0x0002, each with a one-cycle mem_we.
- Then RUN: cpu_rst=0, done=1.
REQ-040 Zero length: bytes 00 00 -> RUN with no mem_we pulse.
REQ-041 Backpressure and wrap: BASE_ADDR=16'hFFFE, 2 words sent with random byte_valid gaps.
- Writes occur at 0xFFFE then 0x0000.
- byte_ready=0 during WRITE; no byte is lost or duplicated.
REQ-042 Timeout: TIMEOUT=16; stall after 3 bytes -> err=1 and IDLE on the 16th idle cycle, cpu_rst=1, busy=0.
REQ-043 Run passthrough and reload:
- In RUN, cpu_we=1 with cpu_addr=0x0100 and cpu_dout=0x1234 -> same values on the mem_* outputs in the same cycle.
- start -> cpu_rst=1 the next cycle and state LEN_HI.

Source files
------------

// File: rtl/boot_loader.sv
// Byte-stream program loader: receives a word count and big-endian words,
// writes them into memory from BASE_ADDR, then releases the CPU onto the memory port.
module boot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] TIMEOUT   = 16'd65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic        cpu_oe,
    input  logic        cpu_we,
    output logic [15:0] cpu_din,
    output logic        cpu_rst,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic [15:0] idle_q, idle_d;
    logic        err_q, err_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        load_state;
    logic        accept;
    logic [15:0] idle_inc;
    logic [15:0] len_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= BASE_ADDR;
            cnt_q     <= 16'h0000;
            data_q    <= 16'h0000;
            idle_q    <= 16'h0000;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            idle_q    <= idle_d;
            err_q     <= err_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        idle_d     = idle_q;
        err_d      = err_q;
        load_state = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                     (state_q == DATA_HI) || (state_q == DATA_LO);
        accept     = load_state && byte_valid;
        idle_inc   = idle_q + 16'd1;
        len_word   = {cnt_q[15:8], byte_data};

        if (load_state) begin
            idle_d = accept ? 16'h0000 : idle_inc;
        end

        unique case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    state_d = LEN_HI;
                    err_d   = 1'b0;
                    idle_d  = 16'h0000;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    cnt_d   = {byte_data, 8'h00};
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    cnt_d = len_word;
                    if (len_word == 16'h0000) begin
                        state_d = RUN;
                    end else begin
                        ptr_d   = BASE_ADDR;
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    data_d[15:8] = byte_data;
                    state_d      = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    data_d[7:0] = byte_data;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                ptr_d   = ptr_q + 16'd2;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? RUN : DATA_HI;
            end
            default: state_d = IDLE;
        endcase

        // A stalled sender aborts the load on the cycle the idle count hits the limit.
        if (load_state && !accept && (idle_inc == TIMEOUT)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end

        cpu_rst_d = (state_d != RUN);
    end

    assign byte_ready = load_state;
    assign busy       = load_state || (state_q == WRITE);
    assign done       = (state_q == RUN);
    assign err        = err_q;
    assign cpu_rst    = cpu_rst_q;
    assign cpu_din    = mem_rdata;
    assign mem_addr   = done ? cpu_addr : ptr_q;
    assign mem_wdata  = done ? cpu_dout : data_q;
    assign mem_oe     = done ? cpu_oe : 1'b0;
    assign mem_we     = done ? cpu_we : (state_q == WRITE);

endmodule

// File: tb/tb_boot_loader.sv
// Drives two loaders (default parameters, and BASE_ADDR=FFFE/TIMEOUT=16) with shared
// stimulus and checks their memory writes against address/word lists built from the load.
module tb_boot_loader;

    localparam logic [15:0] BASE_A = 16'h0000;
    localparam logic [15:0] BASE_B = 16'hFFFE;
    localparam int          TMO_B  = 16;

    logic        clk = 1'b0;
    logic        rst, start, byte_valid, cpu_oe, cpu_we;
    logic [7:0]  byte_data;
    logic [15:0] cpu_addr, cpu_dout, mem_rdata;

    logic        a_byte_ready, a_cpu_rst, a_mem_oe, a_mem_we, a_busy, a_done, a_err;
    logic [15:0] a_cpu_din, a_mem_addr, a_mem_wdata;
    logic        b_byte_ready, b_cpu_rst, b_mem_oe, b_mem_we, b_busy, b_done, b_err;
    logic [15:0] b_cpu_din, b_mem_addr, b_mem_wdata;

    int tests = 0;
    int fails = 0;
    int ready_viol = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wb_q[$];
    logic [15:0] words[$];

    boot_loader dut_a (
        .clk(clk), .rst(rst), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(a_byte_ready), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_oe(cpu_oe),
        .cpu_we(cpu_we), .cpu_din(a_cpu_din), .cpu_rst(a_cpu_rst), .mem_rdata(mem_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_oe(a_mem_oe), .mem_we(a_mem_we),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    boot_loader #(.BASE_ADDR(BASE_B), .TIMEOUT(16'(TMO_B))) dut_b (
        .clk(clk), .rst(rst), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(b_byte_ready), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_oe(cpu_oe),
        .cpu_we(cpu_we), .cpu_din(b_cpu_din), .cpu_rst(b_cpu_rst), .mem_rdata(mem_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_oe(b_mem_oe), .mem_we(b_mem_we),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    // Loader-driven writes, one entry per cycle of mem_we outside RUN.
    always @(negedge clk) begin
        if (rst && a_mem_we && !a_done) begin
            wa_q.push_back({a_mem_addr, a_mem_wdata});
            if (a_byte_ready) ready_viol++;
        end
        if (rst && b_mem_we && !b_done) begin
            wb_q.push_back({b_mem_addr, b_mem_wdata});
            if (b_byte_ready) ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected write list: word i lands at base + 2*i, modulo 2^16.
    task automatic check_writes(input string tag, input int sel, input logic [15:0] base);
        logic [31:0] got[$];
        logic [31:0] obs;
        logic [15:0] addr;
        got = (sel != 0) ? wb_q : wa_q;
        check($sformatf("%s_count", tag), 32'(got.size()), 32'(words.size()));
        for (int i = 0; i < words.size(); i++) begin
            addr = 16'((int'(base) + 2 * i) & 32'hFFFF);
            obs  = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
            check($sformatf("%s_w%0d", tag, i), obs, {addr, words[i]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (a_byte_ready) begin
                @(negedge clk);
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        byte_valid = 1'b0;
        if (!accepted) check("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends the count and every word in 'words'; gaps are random in [0, gapmax].
    task automatic load(input bit do_start, input int gapmax);
        logic [15:0] n;
        n = 16'(words.size());
        if (do_start) pulse_start();
        send_byte(n[15:8], $urandom_range(0, gapmax));
        send_byte(n[7:0], $urandom_range(0, gapmax));
        foreach (words[i]) begin
            send_byte(words[i][15:8], $urandom_range(0, gapmax));
            send_byte(words[i][7:0], $urandom_range(0, gapmax));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_flags"}, {25'd0, a_busy, a_done, a_err, a_cpu_rst, a_byte_ready, a_mem_we, a_mem_oe},
              {25'd0, 7'b0001000});
        check({tag, "_a_mem"}, {a_mem_addr, a_mem_wdata}, {BASE_A, 16'h0000});
        check({tag, "_b_flags"}, {25'd0, b_busy, b_done, b_err, b_cpu_rst, b_byte_ready, b_mem_we, b_mem_oe},
              {25'd0, 7'b0001000});
        check({tag, "_b_mem"}, {b_mem_addr, b_mem_wdata}, {BASE_B, 16'h0000});
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        cpu_addr = 16'h0; cpu_dout = 16'h0; cpu_oe = 1'b0; cpu_we = 1'b0; mem_rdata = 16'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Basic load: 00 02 AA BB CC DD
        wa_q.delete(); wb_q.delete();
        words = '{16'hAABB, 16'hCCDD};
        load(1, 0);
        check_writes("basic_a", 0, BASE_A);
        check_writes("basic_b", 1, BASE_B);
        check("basic_run", {29'd0, a_done, a_cpu_rst, a_busy}, {29'd0, 3'b100});
        $display("[TB] basic load: %0d writes seen", wa_q.size());

        // Zero length, issued from RUN as a reload
        wa_q.delete(); wb_q.delete();
        words.delete();
        load(1, 2);
        check("zero_writes", 32'(wa_q.size() + wb_q.size()), 32'd0);
        check("zero_run", {30'd0, a_done, a_cpu_rst}, {30'd0, 2'b10});
        $display("[TB] zero length load");

        // Passthrough in RUN
        cpu_addr = 16'h0100; cpu_dout = 16'h1234; cpu_we = 1'b1; cpu_oe = 1'b1;
        mem_rdata = 16'($urandom);
        #1;
        check("pass_mem", {a_mem_addr, a_mem_wdata}, {16'h0100, 16'h1234});
        check("pass_ctl", {30'd0, a_mem_we, a_mem_oe}, {30'd0, 2'b11});
        check("pass_din", {16'd0, a_cpu_din}, {16'd0, mem_rdata});
        cpu_we = 1'b0; cpu_oe = 1'b0;
        @(negedge clk);

        // Reload: cpu_rst back to 1 one cycle after start
        start = 1'b1;
        @(posedge clk); #1;
        check("reload", {28'd0, a_cpu_rst, a_busy, a_byte_ready, a_done}, {28'd0, 4'b1110});
        @(negedge clk);
        start = 1'b0;
        $display("[TB] passthrough and reload");

        // Two random words with gaps: wraps FFFE -> 0000 on the second loader
        wa_q.delete(); wb_q.delete();
        words = '{16'($urandom), 16'($urandom)};
        load(0, 6);
        check_writes("wrap_a", 0, BASE_A);
        check_writes("wrap_b", 1, BASE_B);
        $display("[TB] backpressure/wrap load");

        // Random-length load with a start pulse mid-load that must be ignored
        wa_q.delete(); wb_q.delete();
        words.delete();
        for (int i = 0; i < int'($urandom_range(1, 4)); i++) words.push_back(16'($urandom));
        pulse_start();
        send_byte(8'h00, 1);
        send_byte(8'(words.size()), 0);
        pulse_start();
        foreach (words[i]) begin
            send_byte(words[i][15:8], $urandom_range(0, 5));
            send_byte(words[i][7:0], $urandom_range(0, 5));
        end
        repeat (3) @(negedge clk);
        check_writes("rand_a", 0, BASE_A);
        check_writes("rand_b", 1, BASE_B);
        check("ready_in_write", 32'(ready_viol), 32'd0);
        $display("[TB] random load of %0d words", words.size());

        // Asynchronous reset in DATA_LO
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] async reset mid-load");

        // Timeout on the second loader after 3 bytes
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        for (int i = 1; i <= TMO_B; i++) begin
            @(posedge clk); #1;
            if (i == TMO_B - 1)
                check("tmo_before", {30'd0, b_err, b_busy}, {30'd0, 2'b01});
        end
        check("tmo_b", {27'd0, b_err, b_busy, b_cpu_rst, b_done, b_byte_ready}, {27'd0, 5'b10100});
        check("tmo_a_still_busy", {30'd0, a_err, a_busy}, {30'd0, 2'b01});
        repeat (3) @(negedge clk);
        check("tmo_err_hold", {31'd0, b_err}, 32'd1);
        pulse_start();
        check("tmo_err_clear", {30'd0, b_err, b_busy}, {30'd0, 2'b01});
        $display("[TB] timeout load");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
